serial_negate_scheduler: RTL and testbench
==========================================

Name: serial_negate_scheduler

Overview:
- Shares one bit-serial two's-complement negation engine among N parallel-word requesters.
- Round-robin arbitration picks one requester per transaction.
- The chosen word is serialised LSB-first through the engine and the output bits are reassembled.
- The result is returned with the requester ID and an overflow flag.
- Sits between parallel-bus clients and the serial negation datapath; it is the engine's only sequencer.

Parameters:
- W, 8, operand/result width in bits (>=2).
- N, 4, number of requesters (>=2).
- IDW, $clog2(N), width of requester ID (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  N  per-requester request valid.
- req_data  input  N*W  per-requester operand; requester i occupies bits [i*W +: W].
- req_ready  output  N  one-hot (or zero) accept strobe.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  W  two's complement (negation) of the accepted operand.
- res_id  output  IDW  index of the requester that supplied the operand.
- res_ovf  output  1  operand was the most-negative value (1 followed by W-1 zeros); result equals operand.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - State IDLE; req_ready 0; res_valid 0; res_data 0; res_id 0; res_ovf 0; busy 0.
  - RR pointer last = N-1, so requester 0 has first priority.
  - Engine cleared to copy mode.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Grant g = first i with req_valid[i], searching from last+1 modulo N.
  - req_ready[g] = 1 combinationally in the same cycle; all other req_ready bits 0.
  - On transfer, load opnd_sr <= req_data[g], id <= g, last <= g, bit count <= 0.
  - Engine cleared (copy mode, seen_one 0); go to SHIFT.
  - No req_valid: stay in IDLE, req_ready = 0.
- SHIFT (exactly W cycles):
  - Engine input = opnd_sr[0].
  - Engine output = input while in copy mode, ~input once in invert mode. The output is combinational from the current bit.
  - The engine moves to invert mode after processing the first 1 bit, effective from the next bit.
  - Output bit enters res_sr at the MSB; res_sr shifts right; opnd_sr shifts right.
  - At bit W-1: res_ovf <= (engine in copy mode && input bit == 1).
  - After bit W-1: res_data <= final res_sr, res_valid <= 1, go to DONE.
- DONE:
  - res_valid held high; res_data, res_id and res_ovf stable until res_ready.
  - On res_valid && res_ready, in the next cycle: res_valid <= 0, go to IDLE.
  - No request is accepted in DONE, even if req_valid is present in the same cycle.
- Latency:
  - Accept at cycle t gives res_valid high at t+W+1.
  - Minimum per-word occupancy is W+2 cycles with res_ready tied high.
- Zero operand: engine never leaves copy mode; result 0, res_ovf 0.
- RR pointer updates only on a successful accept. A requester that drops req_valid before grant is simply skipped.
- req_data must be stable only in the accept cycle.
- Reset mid-SHIFT or mid-DONE:
  - Word is dropped, no result is emitted, all outputs return to reset values.
  - After reset, requester 0 has priority.

Decomposition:
- Package serial_neg_pkg holds:
  - state typedef {IDLE, SHIFT, DONE};
  - default W/N constants;
  - a function computing the RR grant index from req_valid and last.
- Sub-module serial_neg_core: the bit engine.
  - Ports: clk, rst, clr, en, in_bit, out_bit (combinational), inv_mode (registered).
  - clr forces copy mode synchronously.
  - inv_mode sets when en && in_bit.
  - The controller instantiates exactly one serial_neg_core.

Test Plan (W=8, N=4):
- req_valid=0001, data0=0x06, res_ready=1 -> res_valid at t+9, res_data=0xFA, res_id=0, res_ovf=0.
- Single requests 0x00, 0x01, 0x80, 0x7F -> results 0x00/0, 0xFF/0, 0x80/ovf=1, 0x81/0.
- All four req_valid held high with distinct data -> grants in order 0,1,2,3,0; res_id sequence matches; each req_ready is a one-cycle pulse.
- Hold res_ready low 5 cycles in DONE while req_valid=1111 -> res_valid stays 1, data/id stable, req_ready stays 0000; release -> IDLE then next grant.
- After grant to 2, only req1 and req3 valid -> next grant 3, then 1.
- Assert rst during SHIFT bit 4 -> all outputs 0 immediately, no result emitted; after release with req_valid=1010 -> requester 1 granted first.

Source files
------------

// File: rtl/serial_neg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_neg_pkg: shared types, default sizes and round-robin grant helper   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package serial_neg_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_N     = 4;
  localparam int RR_MAX_N  = 64;
  localparam int RR_IDXW   = $clog2(RR_MAX_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // First valid requester found searching upward from last+1, wrapping at n.
  function automatic int unsigned rr_grant(input logic [RR_MAX_N-1:0] valid,
                                           input int unsigned         last,
                                           input int unsigned         n);
    int unsigned idx;
    logic        found;
    rr_grant = 0;
    found    = 1'b0;
    for (int unsigned i = 1; i <= RR_MAX_N; i++) begin
      if (!found && i <= n) begin
        idx = last + i;
        if (idx >= n) idx = idx - n;
        if (valid[idx[RR_IDXW-1:0]]) begin
          rr_grant = idx;
          found    = 1'b1;
        end
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_negate_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_negate_scheduler_if: request/result bus between clients and engine  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface serial_negate_scheduler_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [IDW-1:0] res_id;
  logic           res_ovf;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_ovf
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id, res_ovf
  );
endinterface
`default_nettype wire

// File: rtl/serial_neg_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_neg_core: bit-serial two's-complement negation engine (LSB first)   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module serial_neg_core (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  input  wire logic in_bit,
  output logic      out_bit,
  output logic      inv_mode
);

  logic r_inv;

  // Bits up to and including the first 1 pass unchanged; later bits invert.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inv <= 1'b0;
    end else if (clr) begin
      r_inv <= 1'b0;
    end else if (en && in_bit) begin
      r_inv <= 1'b1;
    end
  end

  assign out_bit  = in_bit ^ r_inv;
  assign inv_mode = r_inv;

endmodule
`default_nettype wire

// File: rtl/serial_negate_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_negate_scheduler: round-robin sequencer sharing one serial negator  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module serial_negate_scheduler
  import serial_neg_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  serial_negate_scheduler_if.slave   bus,
  output logic                       busy
);

  localparam int IDW  = $clog2(N);
  localparam int CNTW = $clog2(W);

  state_t          r_state;
  logic [W-1:0]    r_opnd_sr;
  logic [W-1:1]    r_res_sr;
  logic [W-1:0]    r_res_data;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  r_last;
  logic [CNTW-1:0] r_cnt;
  logic            r_res_valid;
  logic            r_ovf;

  logic [IDW-1:0]  w_grant;
  logic            w_accept;
  logic            w_out_bit;
  logic            w_inv_mode;
  logic            w_last_bit;
  logic [W-1:0]    w_res_next;

  assign w_grant    = IDW'(rr_grant(RR_MAX_N'(bus.req_valid), 32'(r_last), N));
  // Reset is folded in so no accept strobe is advertised while reset is held.
  assign w_accept   = (r_state == IDLE) && (|bus.req_valid) && !rst;
  assign w_last_bit = (r_cnt == CNTW'(W - 1));
  assign w_res_next = {w_out_bit, r_res_sr};

  always_comb begin
    bus.req_ready = '0;
    if (w_accept) bus.req_ready[w_grant] = 1'b1;
  end

  serial_neg_core u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_accept),
    .en       (r_state == SHIFT),
    .in_bit   (r_opnd_sr[0]),
    .out_bit  (w_out_bit),
    .inv_mode (w_inv_mode)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_opnd_sr   <= '0;
      r_res_sr    <= '0;
      r_res_data  <= '0;
      r_id        <= '0;
      r_last      <= IDW'(N - 1);
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_opnd_sr <= bus.req_data[int'(w_grant)*W +: W];
            r_id      <= w_grant;
            r_last    <= w_grant;
            r_cnt     <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_opnd_sr <= {1'b0, r_opnd_sr[W-1:1]};
          r_res_sr  <= w_res_next[W-1:1];
          r_cnt     <= r_cnt + 1'b1;
          if (w_last_bit) begin
            // Still copying at the MSB means the operand was 100..0.
            r_ovf       <= !w_inv_mode && r_opnd_sr[0];
            r_res_data  <= w_res_next;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_id    = r_id;
  assign bus.res_ovf   = r_ovf;
  assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_negate_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_negate_scheduler: directed vectors and RR/stall/reset sequences  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_serial_negate_scheduler;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_negate_scheduler_if #(.W(W), .N(N)) bus ();

  serial_negate_scheduler #(.W(W), .N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct {
    int         id;
    logic [7:0] opnd;
    logic [7:0] exp_data;
    logic       exp_ovf;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] rr_exp [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Called on the negedge after the accept edge; returns cycles since accept.
  task automatic wait_res(output int cyc);
    cyc = 1;
    while (!bus.res_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_single(input vec_t v);
    int cyc;
    @(negedge clk);
    bus.req_valid              = onehot(v.id);
    bus.req_data               = '0;
    bus.req_data[v.id*W +: W]  = v.opnd;
    bus.res_ready              = 1'b1;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'(onehot(v.id)));
    @(negedge clk);
    bus.req_valid = '0;
    bus.req_data  = '1;
    chk("single_busy", 32'(busy), 1);
    wait_res(cyc);
    chk("single_latency", cyc, W + 1);
    chk("single_data", 32'(bus.res_data), 32'(v.exp_data));
    chk("single_id", 32'(bus.res_id), v.id);
    chk("single_ovf", 32'(bus.res_ovf), 32'(v.exp_ovf));
    @(negedge clk);
    chk("single_drop_valid", 32'(bus.res_valid), 0);
    chk("single_idle", 32'(busy), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    vecs[0] = '{0, 8'h06, 8'hFA, 1'b0};
    vecs[1] = '{1, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{2, 8'h01, 8'hFF, 1'b0};
    vecs[3] = '{3, 8'h80, 8'h80, 1'b1};
    vecs[4] = '{0, 8'h7F, 8'h81, 1'b0};
    vecs[5] = '{1, 8'h55, 8'hAB, 1'b0};
    vecs[6] = '{2, 8'hFE, 8'h02, 1'b0};
    vecs[7] = '{3, 8'hFF, 8'h01, 1'b0};
    rr_exp  = '{8'hF0, 8'hE0, 8'hD0, 8'hC0};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_data", 32'(bus.res_data), 0);
    chk("rst_id", 32'(bus.res_id), 0);
    chk("rst_ovf", 32'(bus.res_ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_single(vecs[i]);

    // Round robin with all requesters valid: grants 0,1,2,3,0.
    @(negedge clk);
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h40302010;
    bus.res_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 32'(bus.req_ready), 32'(onehot(k % 4)));
      @(negedge clk);
      chk("rr_pulse", 32'(bus.req_ready), 0);
      wait_res(cyc);
      chk("rr_latency", cyc, W + 1);
      chk("rr_id", 32'(bus.res_id), k % 4);
      chk("rr_data", 32'(bus.res_data), 32'(rr_exp[k % 4]));
      @(negedge clk);
    end

    // Consumer stall in DONE with every requester still valid.
    chk("stall_grant", 32'(bus.req_ready), 32'(onehot(1)));
    bus.res_ready = 1'b0;
    @(negedge clk);
    wait_res(cyc);
    chk("stall_first_id", 32'(bus.res_id), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.res_valid), 1);
      chk("stall_data", 32'(bus.res_data), 32'h000000E0);
      chk("stall_id", 32'(bus.res_id), 1);
      chk("stall_ready", 32'(bus.req_ready), 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(bus.res_valid), 0);
    chk("release_grant", 32'(bus.req_ready), 32'(onehot(2)));

    // After grant to 2 only requesters 1 and 3 remain: expect 3 then 1.
    @(negedge clk);
    bus.req_valid = 4'b1010;
    wait_res(cyc);
    chk("skip_id2", 32'(bus.res_id), 2);
    chk("skip_data2", 32'(bus.res_data), 32'h000000D0);
    @(negedge clk);
    chk("skip_grant3", 32'(bus.req_ready), 32'(onehot(3)));
    @(negedge clk);
    wait_res(cyc);
    chk("skip_id3", 32'(bus.res_id), 3);
    chk("skip_data3", 32'(bus.res_data), 32'h000000C0);
    @(negedge clk);
    chk("skip_grant1", 32'(bus.req_ready), 32'(onehot(1)));
    @(negedge clk);
    bus.req_valid = '0;
    wait_res(cyc);
    chk("skip_id1", 32'(bus.res_id), 1);
    chk("skip_data1", 32'(bus.res_data), 32'h000000E0);
    @(negedge clk);

    // Reset in SHIFT bit 4 of a requester-1 word.
    bus.req_valid = onehot(1);
    bus.req_data  = 32'h00002200;
    #1;
    chk("rst_test_grant", 32'(bus.req_ready), 32'(onehot(1)));
    @(negedge clk);
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    chk("rst_test_busy_before", 32'(busy), 1);
    rst           = 1'b1;
    bus.req_valid = 4'b1010;
    #1;
    chk("midrst_valid", 32'(bus.res_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_data", 32'(bus.res_data), 0);
    chk("midrst_id", 32'(bus.res_id), 0);
    chk("midrst_ovf", 32'(bus.res_ovf), 0);
    chk("midrst_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = '0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(bus.res_valid), 0);
    end
    bus.req_valid = 4'b1010;
    bus.req_data  = 32'h33002200;
    #1;
    chk("postrst_grant", 32'(bus.req_ready), 32'(onehot(1)));
    @(negedge clk);
    bus.req_valid = '0;
    wait_res(cyc);
    chk("postrst_latency", cyc, W + 1);
    chk("postrst_id", 32'(bus.res_id), 1);
    chk("postrst_data", 32'(bus.res_data), 32'h000000DE);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
